tree_plru_sets: RTL and testbench
=================================

TREE_PLRU_SETS -- requirements
Module: tree_plru_sets

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 32; way count, power of 2, 2..64.
REQ-002 SHALL have parameter NUM_SETS, default 1; independent PLRU trees, power of 2, 1..256.
REQ-003 SHALL derive local WAY_W = max(1, log2 NUM_WAYS) and SET_W = max(1, log2 NUM_SETS).
REQ-004 clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous and active-low.
REQ-006 update_en  in  1  global gate for state updates.
REQ-007 acc_set  in  SET_W  set index of the access being recorded.
REQ-008 read_access / read_way  in  1 / WAY_W  hit recorded on a read.
REQ-009 write_access / write_way  in  1 / WAY_W  fill recorded on a write.
REQ-010 lkp_set  in  SET_W  set whose victim is reported.
REQ-011 flush_req  in  1  single-cycle pulse; clears every tree.
REQ-012 lru_way  out  WAY_W  pseudo-LRU victim of lkp_set.
REQ-013 busy  out  1  flush in progress.

Function
REQ-014 SHALL hold NUM_WAYS-1 node bits per set, heap-indexed: root node 0, children 2n+1 / 2n+2.
REQ-015 Node bit 0 SHALL point the victim to the lower-way subtree; bit 1 SHALL point it to the upper-way subtree.
REQ-016 Access to way w SHALL set every node on w's root-to-leaf path to point away from w; off-path nodes SHALL be unchanged.
REQ-017 Update SHALL occur at the clk edge when update_en & (read_access | write_access) & !busy, and only in set acc_set.
REQ-018 When read_access and write_access are both high, read_way SHALL win and write_way SHALL be ignored.
REQ-019 lru_way SHALL be combinational from registered state: walk from the root following node bits; 0-cycle lookup, 1-cycle update visibility.
REQ-020 Same-cycle update and lookup of the same set SHALL report the pre-update victim.
REQ-021 FSM states SHALL be IDLE and FLUSH; flush_req in IDLE -> FLUSH with set counter = 0.
REQ-022 FLUSH SHALL clear one set per cycle, counter incrementing; last set cleared -> IDLE; busy=1 exactly NUM_SETS cycles.
REQ-023 flush_req in FLUSH SHALL be ignored.
REQ-024 During FLUSH, updates SHALL be dropped and lru_way SHALL be 0.
REQ-025 Out-of-range way/set values are unreachable by parameter rules; no checks required.

Reset
REQ-026 rst_n=0 at a clk edge SHALL clear all node bits, return the FSM to IDLE and clear the counter.
REQ-027 After reset, busy=0 and lru_way=0.
REQ-028 Reset asserted during FLUSH SHALL abort the flush immediately.
REQ-029 Reset SHALL take priority over flush and updates.

Configuration
REQ-030 With macro PLRU_WAY_LOCK_EN defined, the block SHALL add input lock_mask[NUM_WAYS] and output all_locked.
REQ-031 With lock enabled, at each node the walk SHALL take the pointed subtree unless all of its ways are locked, else the other subtree.
REQ-032 all_locked SHALL be 1 when every bit of lock_mask is set; lru_way SHALL then equal the unlocked-tree result.
REQ-033 Without the macro, there SHALL be no lock ports, and behaviour SHALL be exactly REQ-019.

Structure
REQ-034 Package plru_pkg SHALL hold the FSM state enum and the node-index helper functions (parent/child/leaf-to-node).
REQ-035 The block SHALL have one sub-module, plru_tree_walk: combinational victim walk over one set's bits (plus lock mask when enabled).

Verification
REQ-036 Reset, NUM_WAYS=32 -> lru_way=0, busy=0.
REQ-037 Read way 0 -> next cycle lru_way=16; then read way 16 -> lru_way=8.
REQ-038 Same cycle: read way 3 + write way 5 -> state identical to read of way 3 alone (lru_way=16).
REQ-039 NUM_SETS=4; access set 2 way 0; lkp_set=1 -> lru_way=0, lkp_set=2 -> 16.
REQ-040 NUM_SETS=4, flush_req -> busy high 4 cycles; updates during the flush are dropped; afterwards every set gives lru_way=0.
REQ-041 PLRU_WAY_LOCK_EN: after reset, lock ways 0..15 -> lru_way=16; all ways locked -> all_locked=1, lru_way=0.

Source files
------------

// File: rtl/plru_pkg.sv
// Shared types and heap-index helpers for the tree pseudo-LRU block.
// Node n has children 2n+1 (lower ways) and 2n+2 (upper ways); leaves follow the NUM_WAYS-1 nodes.
package plru_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } flush_state_e;

   function automatic int node_parent(input int n);
      return (n - 1) / 2;
   endfunction

   function automatic int node_child(input int n, input logic upper);
      return 2 * n + 1 + int'(upper);
   endfunction

   function automatic int leaf_to_node(input int way, input int num_ways);
      return num_ways - 1 + way;
   endfunction

endpackage

// File: rtl/plru_tree_walk.sv
// Combinational victim walk over one set's PLRU node bits, root to leaf.
// With PLRU_WAY_LOCK_EN defined, fully locked subtrees are steered around.
module plru_tree_walk
   import plru_pkg::*;
#(
   parameter int NUM_WAYS = 32,
   parameter int WAY_W    = 5
) (
   input  logic [NUM_WAYS-2:0] node_bits_i,
`ifdef PLRU_WAY_LOCK_EN
   input  logic [NUM_WAYS-1:0] lock_mask_i,
   output logic                all_locked_o,
`endif
   output logic [WAY_W-1:0]    way_o
);

`ifdef PLRU_WAY_LOCK_EN
   assign all_locked_o = &lock_mask_i;

   always_comb begin
      logic [2*NUM_WAYS-2:0] full_lock;
      int   n;
      logic dir;
      full_lock = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         full_lock[leaf_to_node(w, NUM_WAYS)] = lock_mask_i[w];
      end
      // Children always sit at higher indices, so a descending sweep builds subtree ANDs bottom-up.
      for (int k = NUM_WAYS - 2; k >= 0; k--) begin
         full_lock[k] = full_lock[node_child(k, 1'b0)] & full_lock[node_child(k, 1'b1)];
      end
      n = 0;
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
         dir = node_bits_i[n];
         if (!all_locked_o && full_lock[node_child(n, dir)]) begin
            dir = ~dir;
         end
         n = node_child(n, dir);
      end
      way_o = WAY_W'(n - (NUM_WAYS - 1));
   end
`else
   always_comb begin
      int n;
      n = 0;
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
         n = node_child(n, node_bits_i[n]);
      end
      way_o = WAY_W'(n - (NUM_WAYS - 1));
   end
`endif

endmodule

// File: rtl/tree_plru_sets.sv
// Tree pseudo-LRU replacement state for NUM_SETS independent sets, with a one-set-per-cycle flush.
// Define PLRU_WAY_LOCK_EN to add the lock_mask input and all_locked output.
module tree_plru_sets
   import plru_pkg::*;
#(
   parameter  int NUM_WAYS = 32,
   parameter  int NUM_SETS = 1,
   localparam int WAY_W    = (NUM_WAYS > 2) ? $clog2(NUM_WAYS) : 1,
   localparam int SET_W    = (NUM_SETS > 2) ? $clog2(NUM_SETS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                update_en,
   input  logic [SET_W-1:0]    acc_set,
   input  logic                read_access,
   input  logic [WAY_W-1:0]    read_way,
   input  logic                write_access,
   input  logic [WAY_W-1:0]    write_way,
   input  logic [SET_W-1:0]    lkp_set,
   input  logic                flush_req,
`ifdef PLRU_WAY_LOCK_EN
   input  logic [NUM_WAYS-1:0] lock_mask,
   output logic                all_locked,
`endif
   output logic [WAY_W-1:0]    lru_way,
   output logic                busy
);

   localparam int NODES = NUM_WAYS - 1;

   flush_state_e     state_q;
   logic [SET_W-1:0] flush_cnt_q;
   logic             busy_q;

   logic [NODES-1:0] tree_q [NUM_SETS];
   logic [NODES-1:0] tree_d [NUM_SETS];

   logic             do_update;
   logic [WAY_W-1:0] upd_way;
   logic [NODES-1:0] path_mask;
   logic [NODES-1:0] path_val;
   logic [WAY_W-1:0] walk_way;

   assign do_update = update_en & (read_access | write_access) & (state_q == ST_IDLE);
   assign upd_way   = read_access ? read_way : write_way;

   // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
   always_comb begin
      int n;
      int p;
      path_mask = '0;
      path_val  = '0;
      n = leaf_to_node(int'(upd_way), NUM_WAYS);
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
         p = node_parent(n);
         path_mask[p] = 1'b1;
         // Arriving from the lower child means the victim must now come from the upper side.
         path_val[p]  = (n == node_child(p, 1'b0));
         n = p;
      end
   end

   always_comb begin
      tree_d = tree_q;
      if (state_q == ST_FLUSH) begin
         tree_d[flush_cnt_q] = '0;
      end else if (do_update) begin
         tree_d[acc_set] = (tree_q[acc_set] & ~path_mask) | (path_val & path_mask);
      end
   end

   // NOTE: the node-bit array is reset because reset must leave every set with victim way 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            tree_q[s] <= '0;
         end
      end else begin
         tree_q <= tree_d;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (flush_req) begin
                  state_q     <= ST_FLUSH;
                  flush_cnt_q <= '0;
                  busy_q      <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (flush_cnt_q == SET_W'(NUM_SETS - 1)) begin
                  state_q     <= ST_IDLE;
                  flush_cnt_q <= '0;
                  busy_q      <= 1'b0;
               end else begin
                  flush_cnt_q <= flush_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   plru_tree_walk #(
      .NUM_WAYS (NUM_WAYS),
      .WAY_W    (WAY_W)
   ) u_walk (
      .node_bits_i  (tree_q[lkp_set]),
`ifdef PLRU_WAY_LOCK_EN
      .lock_mask_i  (lock_mask),
      .all_locked_o (all_locked),
`endif
      .way_o        (walk_way)
   );

   assign lru_way = busy_q ? '0 : walk_way;
   assign busy    = busy_q;

endmodule

// File: tb/tb_tree_plru_sets.sv
// Scoreboard bench for tree_plru_sets (32 ways, 4 sets) against a range-based PLRU model.
module tb_tree_plru_sets;

   localparam int NW = 32;
   localparam int NS = 4;
   localparam int WW = 5;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst_n, update_en, read_access, write_access, flush_req;
   logic [WW-1:0] read_way, write_way, lru_way;
   logic [SW-1:0] acc_set, lkp_set;
   logic          busy;
   logic [NW-1:0] lock_next = '0;
`ifdef PLRU_WAY_LOCK_EN
   logic [NW-1:0] lock_mask;
   logic          all_locked;
`endif

   always #5 clk = ~clk;

   tree_plru_sets #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .update_en    (update_en),
      .acc_set      (acc_set),
      .read_access  (read_access),
      .read_way     (read_way),
      .write_access (write_access),
      .write_way    (write_way),
      .lkp_set      (lkp_set),
      .flush_req    (flush_req),
`ifdef PLRU_WAY_LOCK_EN
      .lock_mask    (lock_mask),
      .all_locked   (all_locked),
`endif
      .lru_way      (lru_way),
      .busy         (busy)
   );

   typedef struct {
      int    lru;
      bit    busy;
      bit    lock_all;
      string name;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model: one direction bit per (set, level, position of the range at that level); 1 = upper half.
   bit ptr [NS][WW][NW];
   bit m_flushing;
   int m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void m_clear_set(input int s);
      for (int l = 0; l < WW; l++)
         for (int p = 0; p < NW; p++) ptr[s][l][p] = 1'b0;
   endfunction

   function automatic void m_access(input int s, input int w);
      for (int l = 0; l < WW; l++) begin
         int size = NW >> l;
         ptr[s][l][w / size] = ((w % size) < size / 2);
      end
   endfunction

   function automatic int m_victim(input int s);
      int lo = 0;
      for (int l = 0; l < WW; l++) begin
         int size = NW >> l;
         if (ptr[s][l][lo / size]) lo += size / 2;
      end
      return lo;
   endfunction

   function automatic bit range_locked(input logic [NW-1:0] m, input int lo, input int len);
      for (int i = lo; i < lo + len; i++) if (!m[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int m_victim_lock(input int s, input logic [NW-1:0] m);
      int lo = 0;
      if (&m) return m_victim(s);
      for (int l = 0; l < WW; l++) begin
         int half = (NW >> l) / 2;
         int pick = ptr[s][l][lo / (2 * half)] ? lo + half : lo;
         if (range_locked(m, pick, half)) pick = (pick == lo) ? lo + half : lo;
         lo = pick;
      end
      return lo;
   endfunction

   function automatic int m_expect_way(input int s);
`ifdef PLRU_WAY_LOCK_EN
      return m_victim_lock(s, lock_next);
`else
      return m_victim(s);
`endif
   endfunction

   // One clock of stimulus: drive, queue the expected output for this cycle, then advance the model.
   task automatic step(input bit rst, input bit ue, input bit ra, input int rw, input bit wa,
                       input int ww, input int aset, input int lset, input bit fr,
                       input bit use_c, input int c_lru, input bit c_busy, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n        = rst;
      update_en    = ue;
      read_access  = ra;
      read_way     = rw[WW-1:0];
      write_access = wa;
      write_way    = ww[WW-1:0];
      acc_set      = aset[SW-1:0];
      lkp_set      = lset[SW-1:0];
      flush_req    = fr;
`ifdef PLRU_WAY_LOCK_EN
      lock_mask    = lock_next;
`endif
      e.name     = nm;
      e.busy     = use_c ? c_busy : m_flushing;
      e.lru      = use_c ? c_lru : (m_flushing ? 0 : m_expect_way(lset));
      e.lock_all = &lock_next;
      sb_q.push_back(e);
      if (!rst) begin
         for (int s = 0; s < NS; s++) m_clear_set(s);
         m_flushing = 1'b0;
         m_cnt      = 0;
      end else if (m_flushing) begin
         m_clear_set(m_cnt);
         m_cnt++;
         if (m_cnt == NS) m_flushing = 1'b0;
      end else begin
         if (ue && (ra || wa)) m_access(aset, ra ? rw : ww);
         if (fr) begin
            m_flushing = 1'b1;
            m_cnt      = 0;
         end
      end
   endtask

   task automatic idle_c(input int lset, input int c_lru, input bit c_busy, input string nm);
      step(1, 0, 0, 0, 0, 0, 0, lset, 0, 1, c_lru, c_busy, nm);
   endtask

   task automatic idle_m(input int lset, input string nm);
      step(1, 0, 0, 0, 0, 0, 0, lset, 0, 0, 0, 0, nm);
   endtask

   task automatic do_reset(input string nm);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, nm);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({e.name, "_lru"}, 32'(lru_way), e.lru);
         check({e.name, "_busy"}, 32'(busy), 32'(e.busy));
`ifdef PLRU_WAY_LOCK_EN
         check({e.name, "_all_locked"}, 32'(all_locked), 32'(e.lock_all));
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; update_en = 1'b0; read_access = 1'b0; write_access = 1'b0;
      read_way = '0; write_way = '0; acc_set = '0; lkp_set = '0; flush_req = 1'b0;
`ifdef PLRU_WAY_LOCK_EN
      lock_mask = '0;
`endif
      for (int s = 0; s < NS; s++) m_clear_set(s);
      m_flushing = 1'b0;
      m_cnt      = 0;
      repeat (3) @(posedge clk);

      idle_c(0, 0, 0, "reset_state");
      step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "same_cycle_pre_update");
      idle_c(0, 16, 0, "after_read0");
      step(1, 1, 1, 16, 0, 0, 0, 0, 0, 0, 0, 0, "read16");
      idle_c(0, 8, 0, "after_read16");
      step(1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, "gated_off");
      idle_c(0, 8, 0, "update_en_low");

      do_reset("reset_mid");
      step(1, 1, 1, 3, 1, 5, 0, 0, 0, 1, 0, 0, "reset_again");
      idle_c(0, 16, 0, "read_beats_write");

      do_reset("reset_sets");
      step(1, 1, 0, 0, 1, 0, 2, 2, 0, 0, 0, 0, "write_set2");
      idle_c(1, 0, 0, "set1_untouched");
      idle_c(2, 16, 0, "set2_updated");

      step(1, 1, 1, 9, 0, 0, 3, 2, 0, 0, 0, 0, "pre_flush");
      step(1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, "flush_req");
      for (int i = 0; i < NS; i++)
         step(1, 1, 1, int'($urandom_range(0, NW - 1)), 0, 0, i, i, (i == 1), 1, 0, 1, "flushing");
      for (int i = 0; i < NS; i++) idle_c(i, 0, 0, "post_flush");

      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "flush_again");
      idle_m(1, "flush_busy");
      do_reset("reset_in_flush");
      idle_c(0, 0, 0, "flush_aborted");

`ifdef PLRU_WAY_LOCK_EN
      do_reset("lock_reset");
      lock_next = 32'h0000_FFFF;
      idle_c(0, 16, 0, "lock_low_half");
      lock_next = '1;
      idle_c(0, 0, 0, "lock_all");
      lock_next = '0;
`endif

      for (int i = 0; i < 600; i++) begin
`ifdef PLRU_WAY_LOCK_EN
         if ($urandom_range(0, 7) == 0) lock_next = NW'($urandom()) & NW'($urandom());
`endif
         step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), int'($urandom_range(0, NW - 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, NW - 1)),
              int'($urandom_range(0, NS - 1)), int'($urandom_range(0, NS - 1)),
              ($urandom_range(0, 31) == 0), 0, 0, 0, "random");
      end

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
